// File: rtl/mod10_digit_display_if.sv
// mod10_digit_display_if
//   Bundles the data/handshake signals of the mod-10 digit display stage.
//   master : producer side (drives digits, load strobe, blanking mode;
//            observes display outputs)
//   slave  : display stage itself
//   Signals:
//     digits_in   4*NUM_DIGITS  BCD digits, digit k = digits_in[4k+3:4k]
//     load        1             capture strobe for digits_in
//     lz_blank    1             leading-zero blanking enable
//     seg_n       7             segments {g,f,e,d,c,b,a}, active-low
//     an_n        NUM_DIGITS    anode enables, active-low
//     frame_done  1             pulse on the last cycle of a scan frame
//     pending     1             shadow holds data not yet shown
interface mod10_digit_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic                    load;
    logic                    lz_blank;
    logic [6:0]              seg_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    frame_done;
    logic                    pending;

    modport master (
        output digits_in, load, lz_blank,
        input  seg_n, an_n, frame_done, pending
    );

    modport slave (
        input  digits_in, load, lz_blank,
        output seg_n, an_n, frame_done, pending
    );
endinterface

// File: rtl/mod10_digit_display.sv
// mod10_digit_display
//   Latches NUM_DIGITS BCD digits into a shadow register and scans them onto a
//   common-anode 7-segment display. The shadow is copied into the displayed
//   register only at frame boundaries so a frame never mixes old and new data.
//   Supports leading-zero blanking and shows '-' for non-BCD codes.
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-high
//     bus    slave side of mod10_digit_display_if (digits_in, load, lz_blank,
//            seg_n, an_n, frame_done, pending)
module mod10_digit_display #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 4,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    mod10_digit_display_if.slave  bus
);

    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TMAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] DRIVE_LAST = TW'(SCAN_DIV - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_t;

    state_t                      state_q, state_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic [TW-1:0]               timer_q, timer_d;

    logic [NUM_DIGITS-1:0][3:0]  shadow_q;
    logic [NUM_DIGITS-1:0][3:0]  display_q;
    logic [NUM_DIGITS-1:0][3:0]  display_d;
    logic                        pending_q;
    logic                        commit;

    logic [6:0]                  seg_q, seg_d;
    logic [NUM_DIGITS-1:0]       an_q, an_d;
    logic                        fd_q, fd_d;

    logic [NUM_DIGITS-1:0]       lz_mask;
    logic                        higher_zero;
    logic [3:0]                  cur_digit;

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    // frame_done is registered, so it marks the current cycle as the last of
    // the frame; the copy happens on the edge that leaves it.
    assign commit    = fd_q & pending_q;
    // Value the display register will hold after this edge. Outputs are
    // computed from it so a zero-blank-cycle configuration shows the newly
    // committed digit 0 immediately.
    assign display_d = commit ? shadow_q : display_q;

    // Scan sequencer: next state, digit index and timer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        unique case (state_q)
            ST_BLANK: begin
                // With BLANK_CYCLES=0 this state is only reached from reset.
                if (BLANK_CYCLES == 0 || timer_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_DRIVE: begin
                if (timer_q == DRIVE_LAST) begin
                    timer_d = '0;
                    idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                    state_d = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_BLANK;
                idx_d   = '0;
                timer_d = '0;
            end
        endcase
    end

    // Leading-zero mask: walk from the most significant digit down, blanking
    // zeros until the first non-zero code. Digit 0 is never blanked.
    always_comb begin
        lz_mask     = '0;
        higher_zero = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (bus.lz_blank && higher_zero &&
                display_d[NUM_DIGITS-1-k] == 4'd0 && k != NUM_DIGITS - 1)
                lz_mask[NUM_DIGITS-1-k] = 1'b1;
            higher_zero = higher_zero && (display_d[NUM_DIGITS-1-k] == 4'd0);
        end
    end

    // Output values for the state being entered; registered below so the
    // pins change on the same edge as the state with no combinational path.
    always_comb begin
        an_d      = '1;
        seg_d     = 7'h7F;
        fd_d      = 1'b0;
        cur_digit = display_d[idx_d];
        if (state_d == ST_DRIVE) begin
            an_d[idx_d] = 1'b0;
            seg_d       = lz_mask[idx_d] ? 7'h7F : encode(cur_digit);
            fd_d        = (idx_d == LAST_IDX) && (timer_d == DRIVE_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_BLANK;
            idx_q     <= '0;
            timer_q   <= '0;
            shadow_q  <= '0;
            display_q <= '0;
            pending_q <= 1'b0;
            seg_q     <= 7'h7F;
            an_q      <= '1;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            display_q <= display_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            fd_q      <= fd_d;
            if (bus.load)
                shadow_q <= bus.digits_in;
            // A load in the commit cycle keeps pending set for the next frame.
            if (bus.load)
                pending_q <= 1'b1;
            else if (commit)
                pending_q <= 1'b0;
        end
    end

    assign bus.seg_n      = seg_q;
    assign bus.an_n       = an_q;
    assign bus.frame_done = fd_q;
    assign bus.pending    = pending_q;

endmodule
